// File: rtl/spi_reg_cmd_if.sv
// Byte-level bus between the SPI byte shifter and the register command decoder.
// The slave modport is the decoder's view; the master modport drives it.
interface spi_reg_cmd_if;
  logic       SS;
  logic       rxValid;
  logic [7:0] rx;
  logic [7:0] tx;
  logic [7:0] status;
  logic       wrStrobe;
  logic [3:0] wrAddr;
  logic [7:0] wrData;
  logic [7:0] ctrl;
  logic       busy;

  modport slave (
    input  SS, rxValid, rx, status,
    output tx, wrStrobe, wrAddr, wrData, ctrl, busy
  );

  modport master (
    output SS, rxValid, rx, status,
    input  tx, wrStrobe, wrAddr, wrData, ctrl, busy
  );
endinterface

// File: rtl/spi_reg_cmd.sv
// SPI register command decoder: the first byte of a frame selects read/write and a start
// address, and the following bytes stream through an auto-incrementing 16-entry map.
module spi_reg_cmd (
  input logic          sysClk,
  input logic          usrReset,
  spi_reg_cmd_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StCmd, StWrite, StRead} state_e;
  localparam logic [7:0] DevId = 8'hA5;

  logic [1:0] ss_sync_q;
  logic       ss_dly_q;
  logic       primed_q;
  logic       armed_q, armed_d;
  logic       ss_s, ss_start, ss_end, upd;
  state_e     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] tx_q, tx_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  // Entry 15 is never written; it only keeps the index range uniform.
  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];

  always_comb begin
    ss_s     = ss_sync_q[1];
    ss_start = ss_dly_q & ~ss_s;
    ss_end   = ~ss_dly_q & ss_s;
    // Only accept a frame start once SS has been seen inactive after reset.
    armed_d  = armed_q | (primed_q & ss_sync_q[0]);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    upd         = 1'b0;
    if (ss_end) begin
      state_d = StIdle;
      upd     = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ss_start && armed_q) begin
            state_d = StCmd;
            upd     = 1'b1;
          end
        end
        StCmd: begin
          if (bus.rxValid) begin
            addr_d  = bus.rx[3:0];
            state_d = bus.rx[7] ? StRead : StWrite;
            upd     = 1'b1;
          end
        end
        StWrite: begin
          if (bus.rxValid) begin
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
            wr_data_d   = bus.rx;
            if (addr_q != 4'hF) regs_d[addr_q] = bus.rx;
            addr_d = addr_q + 4'd1;
            upd    = 1'b1;
          end
        end
        StRead: begin
          if (bus.rxValid) begin
            addr_d = addr_q + 4'd1;
            upd    = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    tx_d = tx_q;
    if (upd) begin
      unique case (state_d)
        StWrite: tx_d = 8'h00;
        StRead:  tx_d = (addr_d == 4'hF) ? bus.status : regs_q[addr_d];
        default: tx_d = DevId;
      endcase
    end
  end

  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) begin
      ss_sync_q   <= 2'b11;
      ss_dly_q    <= 1'b1;
      primed_q    <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= StIdle;
      addr_q      <= 4'h0;
      tx_q        <= DevId;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 4'h0;
      wr_data_q   <= 8'h00;
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
    end else begin
      ss_sync_q   <= {ss_sync_q[0], bus.SS};
      ss_dly_q    <= ss_s;
      primed_q    <= 1'b1;
      armed_q     <= armed_d;
      state_q     <= state_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.wrStrobe = wr_strobe_q;
  assign bus.wrAddr   = wr_addr_q;
  assign bus.wrData   = wr_data_q;
  assign bus.ctrl     = regs_q[0];
  assign bus.busy     = ~ss_s;
endmodule

// File: tb/tb_spi_reg_cmd.sv
// Bench for spi_reg_cmd: directed byte table, hand-written corner frames, then random
// frames checked against a frame-level model of the register map.
module tb_spi_reg_cmd;
  logic sysClk = 1'b0;
  logic usrReset;
  always #5 sysClk = ~sysClk;

  spi_reg_cmd_if bus_if ();
  spi_reg_cmd dut (.sysClk(sysClk), .usrReset(usrReset), .bus(bus_if));

  int checks   = 0;
  int failures = 0;

  // Frame-level model: command byte picks direction and start address, then bytes stream.
  logic [7:0] m_regs [16];
  logic       m_first, m_read;
  logic [3:0] m_addr;

  typedef struct {
    bit         nf;
    logic [7:0] rx;
    logic       stb;
    logic [3:0] wa;
    logic [7:0] tx;
    logic [7:0] ctrl;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_rd(input logic [3:0] a);
    return (a == 4'hF) ? bus_if.status : m_regs[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_first = 1'b0;
    m_read  = 1'b0;
    m_addr  = 4'h0;
  endtask

  task automatic m_byte(input logic [7:0] b, output logic stb, output logic [3:0] wa,
                        output logic [7:0] tx);
    stb = 1'b0;
    wa  = 4'h0;
    if (m_first) begin
      m_first = 1'b0;
      m_read  = b[7];
      m_addr  = b[3:0];
      tx      = m_read ? m_rd(m_addr) : 8'h00;
    end else if (m_read) begin
      m_addr = m_addr + 4'd1;
      tx     = m_rd(m_addr);
    end else begin
      stb = 1'b1;
      wa  = m_addr;
      if (m_addr != 4'hF) m_regs[m_addr] = b;
      m_addr = m_addr + 4'd1;
      tx     = 8'h00;
    end
  endtask

  task automatic apply_reset();
    usrReset = 1'b1;
    @(negedge sysClk);
    @(negedge sysClk);
    usrReset = 1'b0;
    m_clear();
    repeat (3) @(negedge sysClk);
  endtask

  task automatic frame_open();
    bus_if.SS = 1'b0;
    repeat (4) @(negedge sysClk);
    m_first = 1'b1;
    check("open_tx", bus_if.tx, 8'hA5);
    check("open_busy", 8'(bus_if.busy), 8'h01);
  endtask

  task automatic frame_close();
    bus_if.SS = 1'b1;
    repeat (4) @(negedge sysClk);
    m_first = 1'b0;
    check("close_tx", bus_if.tx, 8'hA5);
    check("close_busy", 8'(bus_if.busy), 8'h00);
  endtask

  // Pulses rxValid for one cycle; returns at the negedge where registered outputs reflect it.
  task automatic send(input logic [7:0] b);
    @(negedge sysClk);
    check("strobe_width", 8'(bus_if.wrStrobe), 8'h00);
    bus_if.rxValid = 1'b1;
    bus_if.rx      = b;
    @(negedge sysClk);
    bus_if.rxValid = 1'b0;
  endtask

  // Send a byte and compare every output against the model.
  task automatic send_model(input logic [7:0] b, input string tag);
    logic       stb;
    logic [3:0] wa;
    logic [7:0] tx;
    send(b);
    m_byte(b, stb, wa, tx);
    check({tag, "_stb"}, 8'(bus_if.wrStrobe), 8'(stb));
    if (stb) begin
      check({tag, "_waddr"}, 8'(bus_if.wrAddr), 8'(wa));
      check({tag, "_wdata"}, bus_if.wrData, b);
    end
    check({tag, "_tx"}, bus_if.tx, tx);
    check({tag, "_ctrl"}, bus_if.ctrl, m_regs[0]);
  endtask

  initial begin
    logic       stb;
    logic [3:0] wa;
    logic [7:0] tx;
    int         len;

    bus_if.SS      = 1'b1;
    bus_if.rxValid = 1'b0;
    bus_if.rx      = 8'h00;
    bus_if.status  = 8'hC3;
    apply_reset();

    check("rst_tx", bus_if.tx, 8'hA5);
    check("rst_ctrl", bus_if.ctrl, 8'h00);
    check("rst_strobe", 8'(bus_if.wrStrobe), 8'h00);
    check("rst_busy", 8'(bus_if.busy), 8'h00);

    //              nf  rx     stb   wa     tx     ctrl
    vecs.push_back('{1, 8'h02, 1'b0, 4'h0, 8'h00, 8'h00});
    vecs.push_back('{0, 8'h11, 1'b1, 4'h2, 8'h00, 8'h00});
    vecs.push_back('{0, 8'h22, 1'b1, 4'h3, 8'h00, 8'h00});
    vecs.push_back('{0, 8'h33, 1'b1, 4'h4, 8'h00, 8'h00});
    vecs.push_back('{1, 8'h0E, 1'b0, 4'h0, 8'h00, 8'h00});
    vecs.push_back('{0, 8'h5A, 1'b1, 4'hE, 8'h00, 8'h00});
    vecs.push_back('{1, 8'h70, 1'b0, 4'h0, 8'h00, 8'h00});
    vecs.push_back('{0, 8'h7F, 1'b1, 4'h0, 8'h00, 8'h7F});
    vecs.push_back('{1, 8'h0F, 1'b0, 4'h0, 8'h00, 8'h7F});
    vecs.push_back('{0, 8'h99, 1'b1, 4'hF, 8'h00, 8'h7F});
    vecs.push_back('{1, 8'h8E, 1'b0, 4'h0, 8'h5A, 8'h7F});
    vecs.push_back('{0, 8'h00, 1'b0, 4'h0, 8'hC3, 8'h7F});
    vecs.push_back('{0, 8'h00, 1'b0, 4'h0, 8'h7F, 8'h7F});
    vecs.push_back('{0, 8'h00, 1'b0, 4'h0, 8'h00, 8'h7F});
    vecs.push_back('{1, 8'hB2, 1'b0, 4'h0, 8'h11, 8'h7F});
    vecs.push_back('{0, 8'h00, 1'b0, 4'h0, 8'h22, 8'h7F});
    vecs.push_back('{0, 8'h00, 1'b0, 4'h0, 8'h33, 8'h7F});
    vecs.push_back('{0, 8'h00, 1'b0, 4'h0, 8'h00, 8'h7F});

    foreach (vecs[i]) begin
      if (vecs[i].nf) begin
        if (i > 0) frame_close();
        frame_open();
      end
      send(vecs[i].rx);
      m_byte(vecs[i].rx, stb, wa, tx);
      check($sformatf("vec%0d_stb", i), 8'(bus_if.wrStrobe), 8'(vecs[i].stb));
      if (vecs[i].stb) begin
        check($sformatf("vec%0d_waddr", i), 8'(bus_if.wrAddr), 8'(vecs[i].wa));
        check($sformatf("vec%0d_wdata", i), bus_if.wrData, vecs[i].rx);
      end
      check($sformatf("vec%0d_tx", i), bus_if.tx, vecs[i].tx);
      check($sformatf("vec%0d_ctrl", i), bus_if.ctrl, vecs[i].ctrl);
    end
    frame_close();

    // rxValid landing in the same cycle as the synchronized SS rise must be dropped.
    frame_open();
    send_model(8'h05, "ssend_cmd");
    bus_if.SS = 1'b1;
    @(negedge sysClk);
    @(negedge sysClk);
    bus_if.rxValid = 1'b1;
    bus_if.rx      = 8'hAB;
    @(negedge sysClk);
    bus_if.rxValid = 1'b0;
    m_first = 1'b0;
    check("ssend_strobe", 8'(bus_if.wrStrobe), 8'h00);
    check("ssend_tx", bus_if.tx, 8'hA5);
    check("ssend_busy", 8'(bus_if.busy), 8'h00);
    repeat (3) @(negedge sysClk);
    frame_open();
    send_model(8'h85, "ssend_rd");
    check("ssend_reg5", bus_if.tx, 8'h00);
    frame_close();

    // Reset mid-write with SS held low: frame aborts and stays dead until SS cycles.
    frame_open();
    send_model(8'h00, "rstmid_cmd");
    send_model(8'hAA, "rstmid_wr");
    check("rstmid_ctrl_pre", bus_if.ctrl, 8'hAA);
    @(negedge sysClk);
    usrReset = 1'b1;
    #1;
    check("rstmid_ctrl", bus_if.ctrl, 8'h00);
    check("rstmid_tx", bus_if.tx, 8'hA5);
    @(negedge sysClk);
    usrReset = 1'b0;
    m_clear();
    repeat (4) @(negedge sysClk);
    send(8'h01);
    check("dead_strobe0", 8'(bus_if.wrStrobe), 8'h00);
    check("dead_tx0", bus_if.tx, 8'hA5);
    send(8'h55);
    check("dead_strobe1", 8'(bus_if.wrStrobe), 8'h00);
    check("dead_tx1", bus_if.tx, 8'hA5);
    check("dead_ctrl", bus_if.ctrl, 8'h00);
    frame_close();
    frame_open();
    send_model(8'h01, "rearm_cmd");
    send_model(8'h66, "rearm_wr");
    frame_close();
    frame_open();
    send_model(8'h81, "rearm_rd");
    check("rearm_reg1", bus_if.tx, 8'h66);
    frame_close();

    // Random frames: random command (incl. reserved bits), lengths long enough to wrap.
    for (int f = 0; f < 60; f++) begin
      bus_if.status = 8'($urandom);
      frame_open();
      len = 1 + int'($urandom_range(0, 20));
      for (int k = 0; k < len; k++) begin
        send_model(8'($urandom), $sformatf("rnd%0d_%0d", f, k));
      end
      frame_close();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
